// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file.
// Contents:
//   DEF_DATA_W, DEF_NREGS, DEF_NREAD : default geometry
//   addr_w(nregs)                    : index width for a given register count
//   rf_data_t                        : default-width register word
//   ZERO_VAL                         : value returned by the hardwired-zero register
package regfile_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_NREAD  = 2;

  // An index needs at least one bit, even for a two-entry file.
  function automatic int addr_w(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  typedef logic [DEF_DATA_W-1:0] rf_data_t;

  localparam rf_data_t ZERO_VAL = '0;

endpackage

// File: rtl/regfile_multiport_entry.sv
// One architectural register: DATA_W data flops plus its pending bit.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset (clears data and pending)
//   we       in   write this entry: data <= wdata, pending cleared
//   rsv      in   reserve this entry: pending set (wins over the clear from we)
//   wdata    in   DATA_W write value
//   data     out  DATA_W stored value
//   pending  out  pending (scoreboard) bit
module regfile_entry #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              rsv,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] data,
  output logic              pending
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data    <= '0;
      pending <= 1'b0;
    end else begin
      if (we) begin
        data <= wdata;
      end
      // A reservation in the same cycle as the write belongs to a newer
      // producer, so it must survive the writeback's clear.
      if (rsv) begin
        pending <= 1'b1;
      end else if (we) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file with one write port, NREAD combinational read
// ports and a per-register pending bit (decode reserves, writeback clears).
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read of the
// register being written this cycle returns wr_data (same-cycle forwarding).
// Ports:
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   wr_en       in   write strobe
//   wr_addr     in   ADDR_W write index
//   wr_data     in   DATA_W write value
//   rsv_en      in   reserve strobe (mark rsv_addr pending)
//   rsv_addr    in   ADDR_W register to reserve
//   rd_addr     in   NREAD x ADDR_W read indices
//   rd_data     out  NREAD x DATA_W read values (combinational)
//   rd_pending  out  NREAD pending bits of the addressed registers
//   any_pending out  OR of all pending bits
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NREGS    = DEF_NREGS,
  parameter  int NREAD    = DEF_NREAD,
  parameter  int ZERO_TOP = 1,
  localparam int ADDR_W   = addr_w(NREGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rsv_en,
  input  logic [ADDR_W-1:0]            rsv_addr,
  input  logic [NREAD-1:0][ADDR_W-1:0] rd_addr,
  output logic [NREAD-1:0][DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]             rd_pending,
  output logic                         any_pending
);

  // Number of registers backed by real flops; the hardwired-zero register,
  // when present, is the top index and has no storage.
  localparam int NSTORE = (ZERO_TOP != 0) ? NREGS - 1 : NREGS;

  logic [DATA_W-1:0] reg_q [NREGS];
  logic [NREGS-1:0]  pend_q;

  // Index decode compares against every legal index only, so an out-of-range
  // address (non-power-of-2 NREGS) matches nothing and is simply dropped.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i < NSTORE) begin : g_store
      logic we;
      logic rsv;
      assign we  = wr_en  && (wr_addr  == ADDR_W'(i));
      assign rsv = rsv_en && (rsv_addr == ADDR_W'(i));
      regfile_entry #(.DATA_W(DATA_W)) u_entry (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .rsv     (rsv),
        .wdata   (wr_data),
        .data    (reg_q[i]),
        .pending (pend_q[i])
      );
    end else begin : g_zero
      assign reg_q[i]  = DATA_W'(ZERO_VAL);
      assign pend_q[i] = 1'b0;
    end
  end

  assign any_pending = |pend_q;

`ifdef REGFILE_BYPASS_EN
  // Forwarding only applies to a write that will actually land: in reset,
  // out of range or aimed at the hardwired-zero register it is not visible.
  logic wr_live;
  logic rsv_same;
  assign wr_live  = reset && wr_en && (int'(wr_addr) < NSTORE);
  assign rsv_same = rsv_en && (rsv_addr == wr_addr);
`endif

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [DATA_W-1:0] data_p;
    logic              pend_p;

    always_comb begin
      data_p = '0;
      pend_p = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        if (rd_addr[p] == ADDR_W'(i)) begin
          data_p = reg_q[i];
          pend_p = pend_q[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_live && (rd_addr[p] == wr_addr)) begin
        data_p = wr_data;
        pend_p = rsv_same;
      end
`endif
    end

    assign rd_data[p]    = data_p;
    assign rd_pending[p] = pend_p;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport: a default-geometry instance
// (64-bit, 32 regs, 2 read ports, hardwired-zero top) and a small instance
// (32-bit, 24 regs, 3 read ports, no zero register).
module tb_regfile_multiport;

  localparam int W_BIG = 131;  // {any, pend1, data1, pend0, data0}

  logic clk;
  logic reset;

  // Default instance
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [63:0]      wr_data;
  logic             rsv_en;
  logic [4:0]       rsv_addr;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][63:0] rd_data;
  logic [1:0]       rd_pending;
  logic             any_pending;

  // Small instance
  logic             s_wr_en;
  logic [4:0]       s_wr_addr;
  logic [31:0]      s_wr_data;
  logic             s_rsv_en;
  logic [4:0]       s_rsv_addr;
  logic [2:0][4:0]  s_rd_addr;
  logic [2:0][31:0] s_rd_data;
  logic [2:0]       s_rd_pending;
  logic             s_any_pending;

  int n_checks;
  int n_fail;

  // Reference model of the default instance (post-edge state)
  logic [63:0] m_reg [32];
  logic        m_pend [32];

  logic [W_BIG-1:0] exp_q [$];

  regfile_multiport u_dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_pending  (rd_pending),
    .any_pending (any_pending)
  );

  regfile_multiport #(
    .DATA_W   (32),
    .NREGS    (24),
    .NREAD    (3),
    .ZERO_TOP (0)
  ) u_small (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (s_wr_en),
    .wr_addr     (s_wr_addr),
    .wr_data     (s_wr_data),
    .rsv_en      (s_rsv_en),
    .rsv_addr    (s_rsv_addr),
    .rd_addr     (s_rd_addr),
    .rd_data     (s_rd_data),
    .rd_pending  (s_rd_pending),
    .any_pending (s_any_pending)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_rsv_en = 1'b0; s_rsv_addr = '0;
  endtask

  // Let the current inputs take effect at the next edge, then return
  // 2 time units after it with all strobes dropped.
  task automatic commit();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #2;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Reset state straight after power-up reset
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd0;
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_pending !== 2'b00 || any_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: data=%h pend=%b any=%b, want 0/0/0", rd_data, rd_pending, any_pending);
    end
    // Write reg 5, reserve reg 6, then assert reset mid-cycle
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    commit();
    rd_addr[0] = 5'd5; rd_addr[1] = 5'd6;
    #1;
    n_checks++;
    if (rd_data[0] !== 64'hDEAD || rd_pending[1] !== 1'b1 || any_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: d0=%h p1=%b any=%b, want dead/1/1", rd_data[0], rd_pending[1], any_pending);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_pending !== 2'b00 || any_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: data=%h pend=%b any=%b, want 0/0/0", rd_data, rd_pending, any_pending);
    end
    // Write/reserve attempted while reset is held must be discarded
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'h1111;
    rsv_en = 1'b1; rsv_addr = 5'd5;
    commit();
    n_checks++;
    if (rd_data !== '0 || rd_pending !== 2'b00 || any_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: data=%h pend=%b any=%b, want 0/0/0", rd_data, rd_pending, any_pending);
    end
    reset = 1'b1;
    model_clear();
    #1;
    n_checks++;
    if (rd_data[0] !== 64'h0 || rd_pending[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: d0=%h p0=%b, want 0/0", rd_data[0], rd_pending[0]);
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h1234_5678_9ABC_DEF0;
    commit();
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd3;
    #1;
    n_checks++;
    if (rd_data[0] !== 64'h1234_5678_9ABC_DEF0 || rd_data[1] !== 64'h1234_5678_9ABC_DEF0) begin
      n_fail++;
      $display("FAIL write_read_r3: d0=%h d1=%h, want 123456789abcdef0", rd_data[0], rd_data[1]);
    end
    // Hardwired-zero register ignores writes and reservations
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
    rsv_en = 1'b1; rsv_addr = 5'd31;
    commit();
    rd_addr[0] = 5'd31; rd_addr[1] = 5'd3;
    #1;
    n_checks++;
    if (rd_data[0] !== 64'h0 || rd_pending[0] !== 1'b0 || any_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_reg: d=%h p=%b any=%b, want 0/0/0", rd_data[0], rd_pending[0], any_pending);
    end
    n_checks++;
    if (rd_data[1] !== 64'h1234_5678_9ABC_DEF0) begin
      n_fail++;
      $display("FAIL zero_reg_other: d=%h, want 123456789abcdef0", rd_data[1]);
    end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1'b1; rsv_addr = 5'd7;
    commit();
    rd_addr[0] = 5'd7; rd_addr[1] = 5'd8;
    #1;
    n_checks++;
    if (rd_pending !== 2'b01 || any_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_reserve: pend=%b any=%b, want 01/1", rd_pending, any_pending);
    end
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd42;
    commit();
    #1;
    n_checks++;
    if (rd_data[0] !== 64'd42 || rd_pending[0] !== 1'b0 || any_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_writeback: d=%0d p=%b any=%b, want 42/0/0", rd_data[0], rd_pending[0], any_pending);
    end
    // Write and reserve the same register: newer producer keeps it pending
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd99;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    commit();
    #1;
    n_checks++;
    if (rd_data[0] !== 64'd99 || rd_pending[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_same_idx: d=%0d p=%b, want 99/1", rd_data[0], rd_pending[0]);
    end
    // Different indices on the same edge act independently
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 64'd5;
    rsv_en = 1'b1; rsv_addr = 5'd10;
    commit();
    rd_addr[0] = 5'd8; rd_addr[1] = 5'd10;
    #1;
    n_checks++;
    if (rd_data[0] !== 64'd5 || rd_pending !== 2'b10) begin
      n_fail++;
      $display("FAIL sb_diff_idx: d8=%0d pend=%b, want 5/10", rd_data[0], rd_pending);
    end
    // Drain both outstanding reservations
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'd99;
    commit();
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'd0;
    commit();
    n_checks++;
    if (any_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_drain: any=%b, want 0", any_pending);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] exp_d;
    logic        exp_p;
`ifdef REGFILE_BYPASS_EN
    exp_d = 64'hA5A5; exp_p = 1'b1;
`else
    exp_d = 64'h0;    exp_p = 1'b0;
`endif
    rd_addr[0] = 5'd3; rd_addr[1] = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'hA5A5;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
    n_checks++;
    if (rd_data[1] !== exp_d || rd_pending[1] !== exp_p) begin
      n_fail++;
      $display("FAIL bypass_same_cycle: d=%h p=%b, want %h/%b", rd_data[1], rd_pending[1], exp_d, exp_p);
    end
    n_checks++;
    if (rd_data[0] !== 64'h1234_5678_9ABC_DEF0) begin
      n_fail++;
      $display("FAIL bypass_other_port: d=%h, want 123456789abcdef0", rd_data[0]);
    end
    commit();
    #1;
    n_checks++;
    if (rd_data[1] !== 64'hA5A5 || rd_pending[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_after: d=%h p=%b, want a5a5/1", rd_data[1], rd_pending[1]);
    end
    // Forwarding never applies to the hardwired-zero register
    rd_addr[1] = 5'd31;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'h77;
    #1;
    n_checks++;
    if (rd_data[1] !== 64'h0 || rd_pending[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass_zero_reg: d=%h p=%b, want 0/0", rd_data[1], rd_pending[1]);
    end
    commit();
  endtask

  task automatic test_params();
    s_wr_en = 1'b1; s_wr_addr = 5'd23; s_wr_data = 32'hCAFE_0023;
    commit();
    s_wr_en = 1'b1; s_wr_addr = 5'd14; s_wr_data = 32'h0000_1414;
    commit();
    s_rd_addr[0] = 5'd23; s_rd_addr[1] = 5'd14; s_rd_addr[2] = 5'd30;
    #1;
    n_checks++;
    if (s_rd_data[0] !== 32'hCAFE_0023 || s_rd_data[1] !== 32'h0000_1414) begin
      n_fail++;
      $display("FAIL params_rw: d23=%h d14=%h, want cafe0023/00001414", s_rd_data[0], s_rd_data[1]);
    end
    // Out-of-range write/reserve, read in the same cycle and afterwards
    s_wr_en = 1'b1; s_wr_addr = 5'd30; s_wr_data = 32'hFFFF_FFFF;
    s_rsv_en = 1'b1; s_rsv_addr = 5'd30;
    #1;
    n_checks++;
    if (s_rd_data[2] !== 32'h0 || s_rd_pending[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL params_oor_same: d=%h p=%b, want 0/0", s_rd_data[2], s_rd_pending[2]);
    end
    commit();
    #1;
    n_checks++;
    if (s_rd_data[2] !== 32'h0 || s_rd_pending !== 3'b000 || s_any_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL params_oor: d30=%h pend=%b any=%b, want 0/000/0", s_rd_data[2], s_rd_pending, s_any_pending);
    end
    n_checks++;
    if (s_rd_data[1] !== 32'h0000_1414 || s_rd_data[0] !== 32'hCAFE_0023) begin
      n_fail++;
      $display("FAIL params_no_wrap: d14=%h d23=%h, want 00001414/cafe0023", s_rd_data[1], s_rd_data[0]);
    end
    // Top register is ordinary here: it can be reserved
    s_rsv_en = 1'b1; s_rsv_addr = 5'd23;
    commit();
    #1;
    n_checks++;
    if (s_rd_pending !== 3'b001 || s_any_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL params_top_rsv: pend=%b any=%b, want 001/1", s_rd_pending, s_any_pending);
    end
  endtask

  task automatic test_random();
    logic [W_BIG-1:0] exp_v;
    logic [W_BIG-1:0] got_v;
    logic [63:0]      ed [2];
    logic             ep [2];
    logic             eany;
    int               fails_here;
    fails_here = 0;
    apply_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      // Small address pool half the time to force collisions
      wr_en    = ($urandom_range(0, 99) < 60);
      wr_addr  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(28, 31)) : 5'($urandom_range(0, 31));
      wr_data  = {$urandom, $urandom};
      rsv_en   = ($urandom_range(0, 99) < 40);
      rsv_addr = ($urandom_range(0, 1) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      for (int p = 0; p < 2; p++) begin
        rd_addr[p] = ($urandom_range(0, 1) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      end
      // Expected read values from pre-edge model state
      eany = 1'b0;
      for (int i = 0; i < 32; i++) eany = eany | m_pend[i];
      for (int p = 0; p < 2; p++) begin
        ed[p] = (rd_addr[p] == 5'd31) ? 64'h0 : m_reg[rd_addr[p]];
        ep[p] = (rd_addr[p] == 5'd31) ? 1'b0  : m_pend[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr != 5'd31 && rd_addr[p] == wr_addr) begin
          ed[p] = wr_data;
          ep[p] = rsv_en && (rsv_addr == wr_addr);
        end
`endif
      end
      exp_q.push_back({eany, ep[1], ed[1], ep[0], ed[0]});
      #1;
      got_v = {any_pending, rd_pending[1], rd_data[1], rd_pending[0], rd_data[0]};
      exp_v = exp_q.pop_front();
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        fails_here++;
        if (fails_here <= 20)
          $display("FAIL random cyc %0d: got %h want %h", cyc, got_v, exp_v);
      end
      // Advance model to post-edge state
      if (wr_en && wr_addr != 5'd31) begin
        m_reg[wr_addr]  = wr_data;
        m_pend[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 5'd31) m_pend[rsv_addr] = 1'b1;
      @(posedge clk);
      #1;
    end
    idle();
    if (fails_here > 20)
      $display("FAIL random: %0d mismatching cycles in total", fails_here);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle();
    rd_addr   = '0;
    s_rd_addr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_bypass();
    test_params();
    test_random();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
